// File: rtl/imem_loader_pkg.sv
// Shared definitions for the PCPU instruction-memory loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the loader state encoding and the parameter defaults used by imem_loader.
package imem_loader_pkg;

   localparam int         ADDR_W_DEFAULT     = 8;
   localparam logic [7:0] SYNC_DEFAULT       = 8'hA5;
   localparam int         RST_CYCLES_DEFAULT = 4;
   localparam int         TIMEOUT_DEFAULT    = 1024;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_HI   = 3'd2,
      ST_LO   = 3'd3,
      ST_CSUM = 3'd4,
      ST_BOOT = 3'd5,
      ST_RUN  = 3'd6
   } state_t;

   // A frame is in progress from the LEN byte up to and including the CSUM byte.
   function automatic logic is_frame_state(input state_t s);
      return (s == ST_LEN) || (s == ST_HI) || (s == ST_LO) || (s == ST_CSUM);
   endfunction

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog for an in-progress frame.
// Latency: o_expired is combinational on the TIMEOUT-th consecutive i_inc cycle.
// Backpressure: none; counter simply restarts on i_clear.
//
// Ports:
//   clock      in  system clock
//   reset      in  async active-low reset
//   i_clear    in  restart the idle count (takes priority over i_inc)
//   i_inc      in  one more idle cycle has elapsed
//   o_expired  out this idle cycle is the TIMEOUT-th in a row
module loader_timeout #(
   parameter int TIMEOUT = 1024
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_expired
);

   localparam int               CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] r_cnt;

   // r_cnt holds the number of idle cycles already completed, so the
   // expiry fires during the idle cycle that would make it TIMEOUT.
   assign o_expired = i_inc && (r_cnt == LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clear || o_expired) begin
         r_cnt <= '0;
      end else if (i_inc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Loads framed host bytes into PCPU imem as 16-bit words, then resets and starts the PCPU.
// Latency: im_we one cycle after the LO byte transfer; boot RST_CYCLES cycles after a good CSUM.
// Backpressure: in_ready is low only while the PCPU is held in reset (BOOT); otherwise one byte per cycle.
//
// Ports:
//   clock, reset                 system clock, async active-low reset
//   in_valid/in_data/in_ready    host byte stream (transfer when valid & ready at posedge)
//   im_addr/im_data/im_we        imem synchronous write port
//   cpu_reset/cpu_enable/cpu_start  PCPU control pins
//   busy                         frame in progress (LEN..CSUM)
//   err                          sticky abort flag, cleared by the next accepted SYNC
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_W     = ADDR_W_DEFAULT,
   parameter logic [7:0] SYNC       = SYNC_DEFAULT,
   parameter int         RST_CYCLES = RST_CYCLES_DEFAULT,
   parameter int         TIMEOUT    = TIMEOUT_DEFAULT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_data,
   output logic              im_we,
   output logic              cpu_reset,
   output logic              cpu_enable,
   output logic              cpu_start,
   output logic              busy,
   output logic              err
);

   localparam int               BOOT_W    = $clog2(RST_CYCLES + 1);
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(RST_CYCLES - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_len;
   logic [ADDR_W-1:0]   r_count;
   logic [7:0]          r_hi;
   logic [7:0]          r_csum;
   logic [BOOT_W-1:0]   r_boot_cnt;
   logic                r_err;
   logic                r_im_we;
   logic [ADDR_W-1:0]   r_im_addr;
   logic [15:0]         r_im_data;

   logic                w_xfer;
   logic                w_sync;
   logic                w_busy;
   logic                w_expired;
   logic                w_last;
   logic                w_csum_bad;
   logic [ADDR_W:0]     w_len_full;
   logic [ADDR_W:0]     w_count_inc;

   // in_ready is a pure state decode so the transfer qualifier never loops
   // back through the next-state logic.
   assign in_ready = (r_state != ST_BOOT);
   assign w_xfer   = in_valid && in_ready;
   assign w_sync   = w_xfer && (in_data == SYNC);
   assign w_busy   = is_frame_state(r_state);
   assign busy     = w_busy;
   assign err      = r_err;
   assign im_we    = r_im_we;
   assign im_addr  = r_im_addr;
   assign im_data  = r_im_data;

   // LEN==0 encodes a full memory (2**ADDR_W words); compare one bit wider
   // so the final word of a full load is recognised without wrap ambiguity.
   assign w_len_full  = (r_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, r_len};
   assign w_count_inc = {1'b0, r_count} + {{ADDR_W{1'b0}}, 1'b1};
   assign w_last      = (w_count_inc >= w_len_full);
   assign w_csum_bad  = (r_state == ST_CSUM) && w_xfer && (in_data != r_csum);

   loader_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (w_xfer || !w_busy),
      .i_inc     (w_busy && !w_xfer),
      .o_expired (w_expired)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      cpu_reset   = 1'b0;
      cpu_enable  = 1'b0;
      cpu_start   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_sync) w_state_nxt = ST_LEN;
         end
         ST_LEN: begin
            if (w_xfer)         w_state_nxt = ST_HI;
            else if (w_expired) w_state_nxt = ST_IDLE;
         end
         ST_HI: begin
            if (w_xfer)         w_state_nxt = ST_LO;
            else if (w_expired) w_state_nxt = ST_IDLE;
         end
         ST_LO: begin
            if (w_xfer)         w_state_nxt = w_last ? ST_CSUM : ST_HI;
            else if (w_expired) w_state_nxt = ST_IDLE;
         end
         ST_CSUM: begin
            if (w_xfer)         w_state_nxt = (in_data == r_csum) ? ST_BOOT : ST_IDLE;
            else if (w_expired) w_state_nxt = ST_IDLE;
         end
         ST_BOOT: begin
            cpu_reset = 1'b1;
            if (r_boot_cnt == BOOT_LAST) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            // Enable/start drop combinationally on leaving RUN, so the PCPU is
            // halted in the cycle after SYNC, well before the first im_we.
            cpu_enable = 1'b1;
            cpu_start  = 1'b1;
            if (w_sync) w_state_nxt = ST_LEN;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_len      <= '0;
         r_count    <= '0;
         r_hi       <= '0;
         r_csum     <= '0;
         r_boot_cnt <= '0;
         r_err      <= 1'b0;
         r_im_we    <= 1'b0;
         r_im_addr  <= '0;
         r_im_data  <= '0;
      end else begin
         r_im_we <= 1'b0;

         case (r_state)
            ST_LEN: begin
               if (w_xfer) begin
                  r_len   <= ADDR_W'(in_data);
                  r_count <= '0;
                  r_csum  <= '0;
               end
            end
            ST_HI: begin
               if (w_xfer) begin
                  r_hi   <= in_data;
                  r_csum <= r_csum ^ in_data;
               end
            end
            ST_LO: begin
               if (w_xfer) begin
                  r_csum    <= r_csum ^ in_data;
                  r_im_we   <= 1'b1;
                  r_im_addr <= r_count;
                  r_im_data <= {r_hi, in_data};
                  r_count   <= r_count + ADDR_W'(1);
               end
            end
            default: begin
            end
         endcase

         if (r_state == ST_BOOT) r_boot_cnt <= r_boot_cnt + BOOT_W'(1);
         else                    r_boot_cnt <= '0;

         if (w_csum_bad || w_expired) begin
            r_err <= 1'b1;
         end else if (w_sync && ((r_state == ST_IDLE) || (r_state == ST_RUN))) begin
            r_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table of whole frames plus hand-written
// sequences for halt timing, LEN=0 full load, idle timeout and async reset.
module tb_imem_loader;

   logic        clock    = 1'b0;
   logic        reset    = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data  = 8'h00;
   logic        in_ready;
   logic [7:0]  im_addr;
   logic [15:0] im_data;
   logic        im_we;
   logic        cpu_reset;
   logic        cpu_enable;
   logic        cpu_start;
   logic        busy;
   logic        err;

   imem_loader #(
      .ADDR_W     (8),
      .SYNC       (8'hA5),
      .RST_CYCLES (4),
      .TIMEOUT    (1024)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .im_addr    (im_addr),
      .im_data    (im_data),
      .im_we      (im_we),
      .cpu_reset  (cpu_reset),
      .cpu_enable (cpu_enable),
      .cpu_start  (cpu_start),
      .busy       (busy),
      .err        (err)
   );

   initial forever #5 clock = ~clock;

   // Write log and cpu_reset cycle counter, sampled mid-cycle.
   logic [23:0] wr_q[$];
   int          rst_cnt = 0;

   always @(negedge clock) begin
      if (im_we) wr_q.push_back({im_addr, im_data});
      if (cpu_reset) rst_cnt++;
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one byte from a negedge and hold it until it transfers.
   task automatic send_byte(input logic [7:0] b);
      int waited = 0;
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waited < 64) begin
         @(negedge clock);
         waited++;
      end
      if (waited >= 64) chk("send_ready_wait", {31'b0, in_ready}, 32'd1);
      @(posedge clock);
   endtask

   task automatic idle(input int n);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (n) @(negedge clock);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_in_ready"},   {31'b0, in_ready},   32'd1);
      chk({tag, "_im_we"},      {31'b0, im_we},      32'd0);
      chk({tag, "_im_addr"},    {24'b0, im_addr},    32'd0);
      chk({tag, "_im_data"},    {16'b0, im_data},    32'd0);
      chk({tag, "_cpu_reset"},  {31'b0, cpu_reset},  32'd0);
      chk({tag, "_cpu_enable"}, {31'b0, cpu_enable}, 32'd0);
      chk({tag, "_cpu_start"},  {31'b0, cpu_start},  32'd0);
      chk({tag, "_busy"},       {31'b0, busy},       32'd0);
      chk({tag, "_err"},        {31'b0, err},        32'd0);
   endtask

   typedef struct {
      int          nbytes;
      logic [79:0] bytes;   // byte i at [79-8*i -: 8]
      int          nwr;
      logic [23:0] wa;      // write address j at [23-8*j -: 8]
      logic [47:0] wd;      // write data j at [47-16*j -: 16]
      logic        exp_err;
      logic        exp_run;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int wr_base;
      int rst_base;
      int bad;
      logic [23:0] exp_wr;

      // Bad checksum from reset, good 2-word load, reload, SYNC-as-data, 3-word load.
      vecs[0] = '{5, {8'hA5, 8'h01, 8'hAB, 8'hCD, 8'h00, 40'h0}, 1,
                  {8'h00, 16'h0}, {16'hABCD, 32'h0}, 1'b1, 1'b0};
      vecs[1] = '{7, {8'hA5, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 24'h0}, 2,
                  {8'h00, 8'h01, 8'h00}, {16'h1234, 16'h5678, 16'h0}, 1'b0, 1'b1};
      vecs[2] = '{5, {8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 40'h0}, 1,
                  {8'h00, 16'h0}, {16'h0000, 32'h0}, 1'b0, 1'b1};
      vecs[3] = '{6, {8'h11, 8'hA5, 8'h01, 8'hA5, 8'hA5, 8'h00, 32'h0}, 1,
                  {8'h00, 16'h0}, {16'hA5A5, 32'h0}, 1'b0, 1'b1};
      vecs[4] = '{9, {8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h00}, 3,
                  {8'h00, 8'h01, 8'h02}, {16'h0102, 16'h0304, 16'h0506}, 1'b0, 1'b1};

      // Reset state.
      repeat (2) @(negedge clock);
      chk_reset_values("rst");
      reset = 1'b1;
      @(negedge clock);
      chk_reset_values("post_rst");

      // Table-driven frames.
      for (int v = 0; v < 5; v++) begin
         wr_base  = wr_q.size();
         rst_base = rst_cnt;
         for (int i = 0; i < vecs[v].nbytes; i++) send_byte(vecs[v].bytes[79-8*i -: 8]);
         idle(12);
         chk($sformatf("v%0d_nwr", v), wr_q.size() - wr_base, vecs[v].nwr);
         for (int j = 0; j < vecs[v].nwr && (wr_base + j) < wr_q.size(); j++) begin
            exp_wr = {vecs[v].wa[23-8*j -: 8], vecs[v].wd[47-16*j -: 16]};
            chk($sformatf("v%0d_wr%0d", v, j), wr_q[wr_base + j], exp_wr);
         end
         chk($sformatf("v%0d_err", v), {31'b0, err}, {31'b0, vecs[v].exp_err});
         chk($sformatf("v%0d_cpu_enable", v), {31'b0, cpu_enable}, {31'b0, vecs[v].exp_run});
         chk($sformatf("v%0d_cpu_start", v), {31'b0, cpu_start}, {31'b0, vecs[v].exp_run});
         chk($sformatf("v%0d_boot_cycles", v), rst_cnt - rst_base, vecs[v].exp_run ? 4 : 0);
         chk($sformatf("v%0d_busy", v), {31'b0, busy}, 32'd0);
      end

      // Halt timing on reload while running.
      wr_base = wr_q.size();
      send_byte(8'hA5);
      @(negedge clock);
      in_valid = 1'b0;
      chk("halt_cpu_enable", {31'b0, cpu_enable}, 32'd0);
      chk("halt_cpu_start",  {31'b0, cpu_start},  32'd0);
      chk("halt_busy",       {31'b0, busy},       32'd1);
      chk("halt_no_write",   wr_q.size() - wr_base, 32'd0);
      send_byte(8'h01);
      send_byte(8'hBE);
      send_byte(8'hEF);
      send_byte(8'h51);
      idle(12);
      chk("reload_nwr", wr_q.size() - wr_base, 32'd1);
      if (wr_q.size() > wr_base) chk("reload_wr0", wr_q[wr_base], 24'h00BEEF);
      chk("reload_run", {31'b0, cpu_enable}, 32'd1);

      // LEN=0: full 256-word load, word i holds value i.
      wr_base = wr_q.size();
      send_byte(8'hA5);
      send_byte(8'h00);
      for (int i = 0; i < 256; i++) begin
         send_byte(8'h00);
         send_byte(8'(i));
      end
      send_byte(8'h00);
      idle(12);
      chk("len0_nwr", wr_q.size() - wr_base, 32'd256);
      bad = 0;
      for (int i = 0; i < 256 && (wr_base + i) < wr_q.size(); i++) begin
         if (wr_q[wr_base + i] !== {8'(i), 16'(i)}) bad++;
      end
      chk("len0_bad_words", bad, 32'd0);
      chk("len0_run", {31'b0, cpu_enable}, 32'd1);
      chk("len0_err", {31'b0, err}, 32'd0);

      // Idle timeout mid-frame.
      wr_base = wr_q.size();
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (1023) @(posedge clock);
      @(negedge clock);
      chk("tmo_1023_busy", {31'b0, busy}, 32'd1);
      chk("tmo_1023_err",  {31'b0, err},  32'd0);
      @(negedge clock);
      chk("tmo_busy",     {31'b0, busy},     32'd0);
      chk("tmo_err",      {31'b0, err},      32'd1);
      chk("tmo_in_ready", {31'b0, in_ready}, 32'd1);
      chk("tmo_no_write", wr_q.size() - wr_base, 32'd0);
      send_byte(8'hA5);
      @(negedge clock);
      in_valid = 1'b0;
      chk("tmo_sync_clears_err", {31'b0, err}, 32'd0);
      chk("tmo_sync_busy",       {31'b0, busy}, 32'd1);

      // Async reset with a write in flight.
      wr_base = wr_q.size();
      send_byte(8'h02);
      send_byte(8'h12);
      send_byte(8'h34);
      #1;
      chk("pre_arst_im_we", {31'b0, im_we}, 32'd1);
      reset = 1'b0;
      #1;
      chk_reset_values("arst");
      @(negedge clock);
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      send_byte(8'h56);
      send_byte(8'h78);
      idle(5);
      chk("arst_no_write", wr_q.size() - wr_base, 32'd0);
      chk("arst_busy",     {31'b0, busy},       32'd0);
      chk("arst_halted",   {31'b0, cpu_enable}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
